// File: rtl/alt_select_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : alt_select_fsm_if
// Description : Request/grant bundle between the channel inputs and the
//               alternation selector. The master drives requests; the slave
//               (the selector) returns the grant pulse and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface alt_select_fsm_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int c_LW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  grant;
    logic [c_LW-1:0]  last_ch;
    logic             last_valid;
    logic             busy;
    logic [CNT_W-1:0] switch_count;

    modport master (
        output req,
        input  grant,
        input  last_ch,
        input  last_valid,
        input  busy,
        input  switch_count
    );

    modport slave (
        input  req,
        output grant,
        output last_ch,
        output last_valid,
        output busy,
        output switch_count
    );
endinterface
`default_nettype wire

// File: rtl/alt_select_fsm.sv
`default_nettype none
// ============================================================================
// Module      : alt_select_fsm
// Description : N-channel alternation selector. Emits a one-cycle one-hot
//               grant when a channel other than the last accepted one
//               requests, with optional edge qualification, a selectable
//               simultaneous-request policy, a post-accept lockout and a
//               saturating accept counter. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alt_select_fsm #(
    parameter int N_CH       = 4,
    parameter int EDGE_MODE  = 1,
    parameter int MULTI_MODE = 0,
    parameter int LOCKOUT    = 3,
    parameter int CNT_W      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alt_select_fsm_if.slave    bus_if
);

    localparam int c_LW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_LCW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   req_prev_q, req_prev_d;
    logic [c_LCW-1:0]  lock_q, lock_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [c_LW-1:0]   last_ch_q, last_ch_d;
    logic              last_valid_q, last_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [N_CH-1:0]   w_qual;
    logic              w_single;
    logic [N_CH-1:0]   w_excl;
    logic [N_CH-1:0]   w_cand;
    logic              w_found;
    logic [c_LW-1:0]   w_idx;

    // Candidate selection: qualify requests, drop last_ch once armed, pick lowest index.
    always_comb begin
        w_qual   = (EDGE_MODE != 0) ? (bus_if.req & ~req_prev_q) : bus_if.req;
        w_single = (w_qual != '0) && ((w_qual & (w_qual - N_CH'(1))) == '0);
        w_excl   = '0;
        if (state_q == S_ARMED) begin
            w_excl[last_ch_q] = 1'b1;
        end
        // Without the multi policy, several simultaneous requests void the cycle.
        w_cand  = ((MULTI_MODE != 0) || w_single) ? (w_qual & ~w_excl) : '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found = 1'b1;
                w_idx   = c_LW'(i);
            end
        end
    end

    // Next-state and registered-output logic of the selector FSM.
    always_comb begin
        state_d      = state_q;
        req_prev_d   = bus_if.req;
        lock_d       = lock_q;
        grant_d      = '0;
        last_ch_d    = last_ch_q;
        last_valid_d = last_valid_q;
        count_d      = count_q;
        case (state_q)
            S_IDLE, S_ARMED: begin
                if (w_found) begin
                    grant_d[w_idx] = 1'b1;
                    last_ch_d      = w_idx;
                    last_valid_d   = 1'b1;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (LOCKOUT > 0) begin
                        state_d = S_LOCK;
                        lock_d  = c_LCW'(LOCKOUT);
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_LOCK: begin
                // Requests are ignored here; edge history still tracks req.
                lock_d = lock_q - c_LCW'(1);
                if (lock_q == c_LCW'(1)) begin
                    state_d = S_ARMED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset primes edge history to all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_prev_q   <= '1;
            lock_q       <= '0;
            grant_q      <= '0;
            last_ch_q    <= '0;
            last_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_prev_q   <= req_prev_d;
            lock_q       <= lock_d;
            grant_q      <= grant_d;
            last_ch_q    <= last_ch_d;
            last_valid_q <= last_valid_d;
            count_q      <= count_d;
        end
    end

    assign bus_if.grant        = grant_q;
    assign bus_if.last_ch      = last_ch_q;
    assign bus_if.last_valid   = last_valid_q;
    assign bus_if.busy         = (state_q == S_LOCK);
    assign bus_if.switch_count = count_q;

endmodule
`default_nettype wire
